// File: rtl/chg_pkg.sv
// Shared types and helpers for the change dispenser: FSM states, denomination
// indices, unit values (in 50-won steps) and the largest-coin-first selector.
package chg_pkg;

  typedef enum logic [2:0] {IDLE, PICK, PULSE, GAP, FINISH} state_t;

  localparam logic [1:0] D50   = 2'd0;
  localparam logic [1:0] D100  = 2'd1;
  localparam logic [1:0] D500  = 2'd2;
  localparam logic [1:0] D1000 = 2'd3;

  localparam logic [6:0] U50   = 7'd1;
  localparam logic [6:0] U100  = 7'd2;
  localparam logic [6:0] U500  = 7'd10;
  localparam logic [6:0] U1000 = 7'd20;

  function automatic logic [6:0] unit_of(input logic [1:0] idx);
    case (idx)
      D50:     return U50;
      D100:    return U100;
      D500:    return U500;
      default: return U1000;
    endcase
  endfunction

  // Returns {found, idx}; units ascend with idx, so the last hit is the largest coin.
  function automatic logic [2:0] pick_denom(input logic [6:0] rem, input logic [3:0] avail);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (avail[i] && (unit_of(2'(i)) <= rem)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/coin_inv_cnt.sv
// One denomination's coin inventory: decrements on dispense, adds refills,
// and saturates at all-ones.
module coin_inv_cnt #(
  parameter int W    = 4,
  parameter int INIT = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         dec_i,
  input  logic         add_i,
  input  logic [W-1:0] qty_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   sum;

  // dec_i is only raised on a non-empty counter, so the extra bit only flags overflow.
  always_comb begin
    sum   = {1'b0, cnt_q} + (add_i ? {1'b0, qty_i} : '0) - {{W{1'b0}}, dec_i};
    cnt_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= W'(INIT);
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/change_dispenser.sv
// Coin-return sequencer: pays a refund largest coin first with a fixed gap between
// pulses. Define CHG_AUDIT_EN to add the AuditCoins dispensed-coin counter.
module change_dispenser
  import chg_pkg::*;
#(
  parameter int INV_W      = 4,
  parameter int INIT_CNT   = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Req,
  input  logic [6:0]       Amount,
  input  logic             Refill,
  input  logic [1:0]       RefillSel,
  input  logic [INV_W-1:0] RefillQty,
  output logic             Busy,
  output logic             Return50,
  output logic             Return100,
  output logic             Return500,
  output logic             Return1000,
  output logic             Finish,
  output logic             Short,
`ifdef CHG_AUDIT_EN
  output logic [15:0]      AuditCoins,
`endif
  output logic [6:0]       Remaining
);

  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     state_q;
  logic [6:0] rem_q;
  logic [1:0] sel_q;
  logic [7:0] gap_q;
  logic       busy_q;
  logic [3:0] ret_q;
  logic       finish_q;
  logic       short_q;
  logic [6:0] remaining_q;

  logic [INV_W-1:0] inv_cnt [4];
  logic [3:0]       inv_dec;
  logic [3:0]       avail;
  logic [6:0]       pick_rem;
  logic             pick_now;
  logic [2:0]       pick_res;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_inv
      assign inv_dec[gi] = (state_q == PULSE) && (sel_q == 2'(gi));
      assign avail[gi]   = inv_dec[gi] ? (inv_cnt[gi] > INV_W'(1)) : (inv_cnt[gi] != '0);
      coin_inv_cnt #(.W(INV_W), .INIT(INIT_CNT)) u_inv (
        .clk_i (CLK),
        .rst_i (RST),
        .dec_i (inv_dec[gi]),
        .add_i (Refill && (RefillSel == 2'(gi))),
        .qty_i (RefillQty),
        .cnt_o (inv_cnt[gi])
      );
    end
  endgenerate

  // Selection is folded into the last gap cycle (or the pulse itself when there is
  // no gap), so coins come out GAP_CYCLES+1 apart; PICK is only a state after IDLE.
  assign pick_rem = (state_q == PULSE) ? (rem_q - unit_of(sel_q)) : rem_q;
  assign pick_now = (state_q == PICK) || ((state_q == GAP) && (gap_q == 8'd0)) ||
                    ((state_q == PULSE) && (GAP_CYCLES == 0));
  assign pick_res = pick_denom(pick_rem, avail);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      sel_q       <= D50;
      gap_q       <= '0;
      busy_q      <= 1'b0;
      ret_q       <= '0;
      finish_q    <= 1'b0;
      short_q     <= 1'b0;
      remaining_q <= '0;
    end else begin
      ret_q    <= '0;
      finish_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Req) begin
            busy_q      <= 1'b1;
            short_q     <= 1'b0;
            remaining_q <= '0;
            if (Amount != 7'd0) begin
              rem_q   <= Amount;
              state_q <= PICK;
            end else begin
              state_q  <= FINISH;
              finish_q <= 1'b1;
            end
          end
        end
        PULSE: begin
          rem_q <= pick_rem;
          if (GAP_CYCLES > 0) begin
            state_q <= GAP;
            gap_q   <= GAP_LOAD;
          end
        end
        GAP: if (gap_q != 8'd0) gap_q <= gap_q - 8'd1;
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: ;
      endcase
      if (pick_now) begin
        if (pick_rem == 7'd0) begin
          state_q  <= FINISH;
          finish_q <= 1'b1;
        end else if (pick_res[2]) begin
          state_q <= PULSE;
          sel_q   <= pick_res[1:0];
          ret_q   <= 4'b0001 << pick_res[1:0];
        end else begin
          short_q     <= 1'b1;
          remaining_q <= pick_rem;
          state_q     <= FINISH;
          finish_q    <= 1'b1;
        end
      end
    end
  end

`ifdef CHG_AUDIT_EN
  logic [15:0] audit_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                   audit_q <= '0;
    else if (state_q == PULSE) audit_q <= audit_q + 16'd1;
  end
  assign AuditCoins = audit_q;
`endif

  assign Busy       = busy_q;
  assign Return50   = ret_q[D50];
  assign Return100  = ret_q[D100];
  assign Return500  = ret_q[D500];
  assign Return1000 = ret_q[D1000];
  assign Finish     = finish_q;
  assign Short      = short_q;
  assign Remaining  = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: scenario tasks plus randomized refunds
// compared against a greedy coin-change model of the inventory.
module tb_change_dispenser;

  localparam int GAP  = 2;
  localparam int MAXC = 15;
  localparam int INIT = 8;
  localparam int UNITS [4] = '{1, 2, 10, 20};

  logic       CLK = 1'b0;
  logic       RST;
  logic       Req;
  logic [6:0] Amount;
  logic       Refill;
  logic [1:0] RefillSel;
  logic [3:0] RefillQty;
  logic       Busy, Return50, Return100, Return500, Return1000, Finish, Short;
  logic [6:0] Remaining;
`ifdef CHG_AUDIT_EN
  logic [15:0] AuditCoins;
  int          maudit;
`endif

  int checks   = 0;
  int failures = 0;
  int minv [4];

  change_dispenser #(.INV_W(4), .INIT_CNT(INIT), .GAP_CYCLES(GAP)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Req        (Req),
    .Amount     (Amount),
    .Refill     (Refill),
    .RefillSel  (RefillSel),
    .RefillQty  (RefillQty),
    .Busy       (Busy),
    .Return50   (Return50),
    .Return100  (Return100),
    .Return500  (Return500),
    .Return1000 (Return1000),
    .Finish     (Finish),
    .Short      (Short),
`ifdef CHG_AUDIT_EN
    .AuditCoins (AuditCoins),
`endif
    .Remaining  (Remaining)
  );

  always #5 CLK = ~CLK;

  task automatic model_refill(input int sel, input int qty);
    minv[sel] = (minv[sel] + qty > MAXC) ? MAXC : minv[sel] + qty;
  endtask

  task automatic check_inv(input string tag);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'(dut.inv_cnt[i]) !== minv[i]) begin
        failures++;
        $display("FAIL %s inv[%0d] got=%0d exp=%0d", tag, i, dut.inv_cnt[i], minv[i]);
      end
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) minv[i] = INIT;
`ifdef CHG_AUDIT_EN
    maudit = 0;
`endif
  endtask

  task automatic do_refill(input int sel, input int qty);
    @(negedge CLK);
    Refill = 1'b1; RefillSel = 2'(sel); RefillQty = 4'(qty);
    @(negedge CLK);
    Refill = 1'b0;
    model_refill(sel, qty);
    $display("refill sel=%0d qty=%0d", sel, qty);
  endtask

  // One refund transaction; optional busy-time Req and mid-run refill (cycle 0 = none).
  task automatic run_refund(input int amount, input int req2_cyc, input int ref_cyc,
                            input int ref_sel, input int ref_qty, input string tag);
    int exp_den[$];
    int rem, d, exp_fin, fin_cyc, got_n, busy_n;
    logic [3:0] pulses;
    rem = amount;
    while (rem > 0) begin
      d = -1;
      for (int i = 3; i >= 0; i--) if (d < 0 && UNITS[i] <= rem && minv[i] > 0) d = i;
      if (d < 0) break;
      exp_den.push_back(d);
      rem -= UNITS[d];
      minv[d]--;
    end
    exp_fin = (amount == 0) ? 1 : 2 + (GAP + 1) * exp_den.size();
    if (ref_cyc > 0) model_refill(ref_sel, ref_qty);
`ifdef CHG_AUDIT_EN
    maudit += exp_den.size();
`endif

    @(negedge CLK);
    Req = 1'b1; Amount = 7'(amount);
    @(negedge CLK);
    fin_cyc = 0; got_n = 0; busy_n = 0;
    for (int k = 1; k <= 500 && fin_cyc == 0; k++) begin
      if (k > 1) @(negedge CLK);
      Req = 1'b0; Refill = 1'b0;
      pulses = {Return1000, Return500, Return100, Return50};
      if (Busy) busy_n++;
      if ($countones(pulses) > 1) begin
        checks++; failures++;
        $display("FAIL %s onehot cycle=%0d pulses=%b", tag, k, pulses);
      end else if (pulses != 4'b0) begin
        d = Return1000 ? 3 : Return500 ? 2 : Return100 ? 1 : 0;
        checks++;
        if (got_n >= exp_den.size()) begin
          failures++;
          $display("FAIL %s extra_pulse cycle=%0d denom=%0d", tag, k, d);
        end else if (d != exp_den[got_n] || k != 2 + (GAP + 1) * got_n) begin
          failures++;
          $display("FAIL %s pulse%0d got denom=%0d cycle=%0d exp denom=%0d cycle=%0d",
                   tag, got_n, d, k, exp_den[got_n], 2 + (GAP + 1) * got_n);
        end
        got_n++;
      end
      if (Finish) fin_cyc = k;
      if (k == req2_cyc) begin Req = 1'b1; Amount = 7'd20; end
      if (k == ref_cyc) begin
        Refill = 1'b1; RefillSel = 2'(ref_sel); RefillQty = 4'(ref_qty);
      end
    end
    Req = 1'b0; Refill = 1'b0;

    checks++;
    if (fin_cyc != exp_fin) begin
      failures++;
      $display("FAIL %s finish_cycle got=%0d exp=%0d", tag, fin_cyc, exp_fin);
    end
    checks++;
    if (got_n != exp_den.size()) begin
      failures++;
      $display("FAIL %s pulse_count got=%0d exp=%0d", tag, got_n, exp_den.size());
    end
    checks++;
    if (busy_n != exp_fin) begin
      failures++;
      $display("FAIL %s busy_cycles got=%0d exp=%0d", tag, busy_n, exp_fin);
    end
    checks++;
    if (Short !== (rem > 0) || int'(Remaining) !== rem) begin
      failures++;
      $display("FAIL %s short/remaining got=%b/%0d exp=%b/%0d", tag, Short, Remaining, rem > 0, rem);
    end
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after_finish got=%b exp=0", tag, Busy);
    end
    check_inv(tag);
`ifdef CHG_AUDIT_EN
    checks++;
    if (int'(AuditCoins) !== maudit) begin
      failures++;
      $display("FAIL %s audit got=%0d exp=%0d", tag, AuditCoins, maudit);
    end
`endif
    $display("refund %s amount=%0d coins=%0d finish=%0d short=%b remaining=%0d",
             tag, amount, got_n, fin_cyc, Short, Remaining);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({Busy, Return50, Return100, Return500, Return1000, Finish, Short, Remaining} !== 13'b0) begin
      failures++;
      $display("FAIL reset outputs got=%b exp=0",
               {Busy, Return50, Return100, Return500, Return1000, Finish, Short, Remaining});
    end
    check_inv("reset");
    $display("reset done");
  endtask

  task automatic test_latency();
    run_refund(3, 0, 0, 0, 0, "latency3");
  endtask

  task automatic test_amount37();
    do_reset();
    run_refund(37, 0, 0, 0, 0, "amount37");
  endtask

  task automatic test_zero();
    run_refund(0, 0, 0, 0, 0, "zero");
  endtask

  task automatic test_busy_req();
    run_refund(3, 2, 0, 0, 0, "busy_req");
  endtask

  task automatic test_short();
    do_reset();
    for (int i = 0; i < 8; i++) run_refund(2, 0, 0, 0, 0, "drain100");
    for (int i = 0; i < 7; i++) run_refund(1, 0, 0, 0, 0, "drain50");
    run_refund(4, 0, 0, 0, 0, "short4");
  endtask

  task automatic test_refill_sat();
    do_reset();
    run_refund(2, 0, 2, 1, 15, "refill_on_pulse");
    run_refund(2, 0, 0, 0, 0, "to14");
    do_refill(1, 3);
    check_inv("refill_sat");
  endtask

  task automatic test_rst_gap();
    do_reset();
    @(negedge CLK);
    Req = 1'b1; Amount = 7'd3;
    repeat (3) begin
      @(negedge CLK);
      Req = 1'b0;
    end
    checks++;
    if (Busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_gap busy_before got=%b exp=1", Busy);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({Busy, Return50, Return100, Return500, Return1000, Finish, Short, Remaining} !== 13'b0) begin
      failures++;
      $display("FAIL rst_gap async_outputs got=%b exp=0",
               {Busy, Return50, Return100, Return500, Return1000, Finish, Short, Remaining});
    end
    for (int i = 0; i < 4; i++) minv[i] = INIT;
`ifdef CHG_AUDIT_EN
    maudit = 0;
`endif
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if (Finish !== 1'b0) begin
        failures++;
        $display("FAIL rst_gap finish_in_reset got=%b exp=0", Finish);
      end
    end
    check_inv("rst_gap");
    RST = 1'b0;
    run_refund(2, 0, 0, 0, 0, "after_rst");
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 1) == 1) do_refill(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      run_refund(int'($urandom_range(0, 127)), 0, 0, 0, 0, "random");
    end
  endtask

  initial begin
    RST = 1'b0; Req = 1'b0; Amount = '0; Refill = 1'b0; RefillSel = '0; RefillQty = '0;
    test_reset();
    test_latency();
    test_amount37();
    test_zero();
    test_busy_req();
    test_short();
    test_refill_sat();
    test_rst_gap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
